tm1638_frame_sequencer: RTL and testbench

Parametrised TM1638 refresh engine. Holds a local copy of the display registers and turns each requested frame into a stream of 18-bit TM1638 command words: data-write setup, per-register address+data, display control and optional key-read. Words go to the downstream TM1638 serial interface over a valid/ready handshake. Sits between the application logic (display contents, brightness) and the bit-level serializer. Unlike one-shot command generation, it tracks dirty registers and only re-sends what changed.

---
 rtl/tm1638_types.sv | 82 ++++++++
 rtl/tm1638_reg_shadow.sv | 86 ++++++++
 rtl/tm1638_frame_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_tm1638_frame_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_types.sv
// Shared TM1638 types: command word layout, command/address/direction enums,
// sequencer FSM states and word-builder functions.
// Latency: none (types and pure functions only). Backpressure: n/a.
package tm1638_types;

  // Width of the frame sequencer scan index; one spare bit above 16 registers.
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    CMD_DATA = 2'b01,
    CMD_CTRL = 2'b10,
    CMD_ADDR = 2'b11
  } command_t;

  typedef enum logic {
    ADDR_AUTO  = 1'b0,
    ADDR_FIXED = 1'b1
  } addr_mode_t;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } data_dir_t;

  // One display register (segment pattern of a grid half).
  typedef logic [7:0] register_t;

  // 18-bit command word handed to the serializer.
  typedef struct packed {
    data_dir_t  dir;
    logic       has_data;
    register_t  data;
    command_t   cmd;
    logic [5:0] args;
  } cmd_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_ADDR,
    S_CTRL,
    S_READ,
    S_DONE
  } seq_state_t;

  // Data command: args = {000, fixed-address, read, 0}.
  function automatic cmd_word_t data_cmd(data_dir_t dir, addr_mode_t mode);
    cmd_word_t w;
    w      = '0;
    w.dir  = dir;
    w.cmd  = CMD_DATA;
    w.args = {3'b000, (mode == ADDR_FIXED), (dir == DIR_READ), 1'b0};
    return w;
  endfunction

  // Display control: args = {00, on, brightness}.
  function automatic cmd_word_t ctrl_cmd(logic on, logic [2:0] level);
    cmd_word_t w;
    w      = '0;
    w.cmd  = CMD_CTRL;
    w.args = {2'b00, on, level};
    return w;
  endfunction

  // Address set followed by one data byte.
  function automatic cmd_word_t addr_cmd(logic [3:0] index, register_t value);
    cmd_word_t w;
    w          = '0;
    w.has_data = 1'b1;
    w.data     = value;
    w.cmd      = CMD_ADDR;
    w.args     = {2'b00, index};
    return w;
  endfunction

  // Key-scan read request.
  function automatic cmd_word_t read_cmd();
    return data_cmd(DIR_READ, ADDR_AUTO);
  endfunction

endpackage

// File: rtl/tm1638_reg_shadow.sv
// Local shadow of the TM1638 display registers with one dirty bit per entry.
// Latency: writes and clears land on the next clock edge; reads are combinational.
// Backpressure: none; a write in the same cycle as a clear wins (entry stays dirty).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data register write port (out-of-range / masked indices ignored)
//   rd_index              read index -> rd_data, rd_dirty
//   any_dirty             OR of all dirty bits
//   clr_en/clr_index      clear dirty bit of an entry whose word was accepted
module tm1638_reg_shadow
  import tm1638_types::*;
#(
  parameter int NUM_GRIDS = 8,
  parameter bit SEG89_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  register_t  wr_data,
  input  logic [3:0] rd_index,
  output register_t  rd_data,
  output logic       rd_dirty,
  output logic       any_dirty,
  input  logic       clr_en,
  input  logic [3:0] clr_index
);

  localparam int NREG = NUM_GRIDS * 2;

  // Odd entries (SEG8/9) only exist when they are refreshed.
  function automatic logic [NREG-1:0] valid_mask_f();
    logic [NREG-1:0] m;
    for (int i = 0; i < NREG; i++) begin
      m[i] = SEG89_EN || ((i % 2) == 0);
    end
    return m;
  endfunction

  localparam logic [NREG-1:0] VALID_MASK = valid_mask_f();

  register_t       regs [NREG];
  logic [NREG-1:0] dirty;
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] clr_hit;

  always_comb begin
    wr_hit  = '0;
    clr_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      wr_hit[i]  = wr_en && VALID_MASK[i] && (wr_addr == 4'(i));
      clr_hit[i] = clr_en && (clr_index == 4'(i));
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_dirty = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_index == 4'(i)) begin
        rd_data  = regs[i];
        rd_dirty = dirty[i];
      end
    end
  end

  assign any_dirty = |dirty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      dirty <= VALID_MASK;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_data;
        end
      end
      dirty <= wr_hit | (dirty & ~clr_hit);
    end
  end

endmodule

// File: rtl/tm1638_frame_sequencer.sv
// TM1638 refresh engine: turns a frame request into setup / address+data /
// control / key-read command words, sending only changed state when DIRTY_ONLY.
// Latency: empty frame pulses frame_done 3 cycles after frame_start; each
// emitted word is registered and held (cmd_valid, cmd_word stable) until cmd_ready.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fb_we/fb_addr/fb_data      display register write port, fb_addr = {grid, seg}
//   brightness, show           display control inputs, sampled when control issues
//   frame_start                one-cycle frame request (ignored unless idle)
//   busy, frame_done           frame in progress / end-of-frame pulse
//   cmd_word/cmd_valid/cmd_ready  command word stream to the serializer
module tm1638_frame_sequencer
  import tm1638_types::*;
#(
  parameter int NUM_GRIDS  = 8,
  parameter bit SEG89_EN   = 1'b1,
  parameter bit DIRTY_ONLY = 1'b1,
  parameter bit KEY_SCAN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fb_we,
  input  logic [3:0]  fb_addr,
  input  logic [7:0]  fb_data,
  input  logic [2:0]  brightness,
  input  logic        show,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic [17:0] cmd_word,
  output logic        cmd_valid,
  input  logic        cmd_ready
);

  localparam int               NREG    = NUM_GRIDS * 2;
  localparam logic [IDX_W-1:0] STEP    = SEG89_EN ? IDX_W'(1) : IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NREG);

  seq_state_t       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  cmd_word_t        cmd_q, cmd_n;
  logic             vld_q, vld_n;

  logic [2:0] last_bright;
  logic       last_show;
  logic       ctrl_dirty;
  logic       latch_ctrl;
  logic       ctrl_acc;
  logic       addr_issue;
  logic       addr_acc;

  // Set when the register behind a pending address word is written after its
  // data was captured; the accept must then leave the entry dirty so the
  // newer value goes out in a later frame.
  logic rewr_q;
  logic wr_same;

  register_t rd_data;
  logic      rd_dirty;
  logic      any_dirty;

  tm1638_reg_shadow #(
    .NUM_GRIDS (NUM_GRIDS),
    .SEG89_EN  (SEG89_EN)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (fb_we),
    .wr_addr   (fb_addr),
    .wr_data   (fb_data),
    .rd_index  (idx[3:0]),
    .rd_data   (rd_data),
    .rd_dirty  (rd_dirty),
    .any_dirty (any_dirty),
    .clr_en    (addr_acc && !rewr_q),
    .clr_index (idx[3:0])
  );

  assign wr_same = fb_we && (fb_addr == idx[3:0]);

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cmd_n      = cmd_q;
    vld_n      = vld_q;
    latch_ctrl = 1'b0;
    ctrl_acc   = 1'b0;
    addr_issue = 1'b0;
    addr_acc   = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_n = S_SETUP;
        end
      end

      S_SETUP: begin
        if (vld_q) begin
          if (cmd_ready) begin
            vld_n   = 1'b0;
            idx_n   = '0;
            state_n = S_SCAN;
          end
        end else if (!DIRTY_ONLY || any_dirty) begin
          cmd_n = data_cmd(DIR_WRITE, ADDR_FIXED);
          vld_n = 1'b1;
        end else begin
          state_n = S_CTRL;
        end
      end

      S_SCAN: begin
        if (idx >= IDX_END) begin
          state_n = S_CTRL;
        end else if (!DIRTY_ONLY || rd_dirty) begin
          state_n = S_ADDR;
        end else begin
          idx_n = idx + STEP;
        end
      end

      S_ADDR: begin
        if (vld_q) begin
          if (cmd_ready) begin
            vld_n    = 1'b0;
            addr_acc = 1'b1;
            idx_n    = idx + STEP;
            state_n  = S_SCAN;
          end
        end else begin
          cmd_n      = addr_cmd(idx[3:0], rd_data);
          vld_n      = 1'b1;
          addr_issue = 1'b1;
        end
      end

      S_CTRL: begin
        if (vld_q) begin
          if (cmd_ready) begin
            ctrl_acc = 1'b1;
            state_n  = S_READ;
            // Preload the key-read word so it follows back-to-back.
            if (KEY_SCAN) begin
              cmd_n = read_cmd();
            end else begin
              vld_n = 1'b0;
            end
          end
        end else if (!DIRTY_ONLY || ctrl_dirty) begin
          cmd_n      = ctrl_cmd(show, brightness);
          vld_n      = 1'b1;
          latch_ctrl = 1'b1;
        end else begin
          state_n = S_READ;
        end
      end

      S_READ: begin
        if (vld_q) begin
          if (cmd_ready) begin
            vld_n   = 1'b0;
            state_n = S_DONE;
          end
        end else if (KEY_SCAN) begin
          cmd_n = read_cmd();
          vld_n = 1'b1;
        end else begin
          state_n = S_DONE;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      cmd_q       <= '0;
      vld_q       <= 1'b0;
      last_bright <= 3'd0;
      last_show   <= 1'b0;
      ctrl_dirty  <= 1'b1;
      rewr_q      <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cmd_q <= cmd_n;
      vld_q <= vld_n;
      if (latch_ctrl) begin
        last_bright <= brightness;
        last_show   <= show;
      end
      // Compared against the value last issued, so a change while the control
      // word is pending keeps the bit set past the accept.
      ctrl_dirty <= ({show, brightness} != {last_show, last_bright}) ||
                    (ctrl_dirty && !ctrl_acc);
      rewr_q <= addr_issue ? wr_same : (rewr_q || wr_same);
    end
  end

  assign cmd_word   = cmd_q;
  assign cmd_valid  = vld_q;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
module tb_tm1638_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fb_we;
  logic [3:0]  fb_addr;
  logic [7:0]  fb_data;
  logic [2:0]  brightness;
  logic        show;
  logic        cmd_ready;
  logic        fs0, fs1, fs2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [17:0] word0, word1, word2;
  logic        vld0, vld1, vld2;

  int checks = 0;
  int errors = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  // Default configuration: 8 grids, SEG8/9, dirty-only, key scan.
  tm1638_frame_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .brightness(brightness), .show(show), .frame_start(fs0), .busy(busy0),
    .frame_done(done0), .cmd_word(word0), .cmd_valid(vld0), .cmd_ready(cmd_ready)
  );

  // No key scan: used for the empty-frame timing.
  tm1638_frame_sequencer #(.KEY_SCAN(1'b0)) u_nk (
    .clk(clk), .rst_n(rst_n), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .brightness(brightness), .show(show), .frame_start(fs1), .busy(busy1),
    .frame_done(done1), .cmd_word(word1), .cmd_valid(vld1), .cmd_ready(cmd_ready)
  );

  // 2 grids, SEG0-7 only, full refresh every frame.
  tm1638_frame_sequencer #(.NUM_GRIDS(2), .SEG89_EN(1'b0), .DIRTY_ONLY(1'b0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .brightness(brightness), .show(show), .frame_start(fs2), .busy(busy2),
    .frame_done(done2), .cmd_word(word2), .cmd_valid(vld2), .cmd_ready(cmd_ready)
  );

  // Capture every transferred word per instance.
  always @(posedge clk) begin
    if (rst_n && cmd_ready) begin
      if (vld0) q0.push_back(word0);
      if (vld1) q1.push_back(word1);
      if (vld2) q2.push_back(word2);
    end
  end

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [2:0]  bri;
    logic        shw;
    logic [17:0] exp_addr;
    logic        has_ctrl;
    logic [17:0] exp_ctrl;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    fb_we = 1'b1; fb_addr = a; fb_data = d;
    @(posedge clk); #1;
    fb_we = 1'b0;
  endtask

  // Pulse frame_start; returns #1 after the edge that samples it.
  task automatic start_frame(input int sel);
    case (sel)
      0: begin q0.delete(); fs0 = 1'b1; end
      1: begin q1.delete(); fs1 = 1'b1; end
      default: begin q2.delete(); fs2 = 1'b1; end
    endcase
    @(posedge clk); #1;
    fs0 = 1'b0; fs1 = 1'b0; fs2 = 1'b0;
  endtask

  // Edges from the frame_start sampling edge until frame_done is seen.
  task automatic wait_done(input int sel, input string name, output int n, output logic b);
    b = busy_of(sel);
    n = 0;
    while (!done_of(sel) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " frame_done seen"}, 32'(done_of(sel)), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_seq(input string name, input int sel);
    logic [17:0] got[$];
    case (sel)
      0: got = q0;
      1: got = q1;
      default: got = q2;
    endcase
    check({name, " word count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size())
        check($sformatf("%s word %0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    end
  endtask

  int   n;
  logic b;
  logic seen;

  initial begin
    vecs[0] = '{addr: 4'd5,  data: 8'hA5, bri: 3'd7, shw: 1'b1, exp_addr: 18'h1A5C5, has_ctrl: 1'b0, exp_ctrl: 18'h0};
    vecs[1] = '{addr: 4'd15, data: 8'hFF, bri: 3'd3, shw: 1'b1, exp_addr: 18'h1FFCF, has_ctrl: 1'b1, exp_ctrl: 18'h0008B};
    vecs[2] = '{addr: 4'd8,  data: 8'h00, bri: 3'd3, shw: 1'b0, exp_addr: 18'h100C8, has_ctrl: 1'b1, exp_ctrl: 18'h00083};
    vecs[3] = '{addr: 4'd1,  data: 8'h80, bri: 3'd3, shw: 1'b0, exp_addr: 18'h180C1, has_ctrl: 1'b0, exp_ctrl: 18'h0};

    rst_n = 1'b0; fb_we = 1'b0; fb_addr = '0; fb_data = '0;
    brightness = 3'd0; show = 1'b0; cmd_ready = 1'b1;
    fs0 = 1'b0; fs1 = 1'b0; fs2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("reset cmd_valid", 32'(vld0), 32'd0);
    check("reset cmd_word", 32'(word0), 32'd0);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset frame_done", 32'(done0), 32'd0);

    // First frame: everything dirty out of reset.
    start_frame(0);
    wait_done(0, "f1", n, b);
    exp_q.delete();
    exp_q.push_back(18'h00044);
    for (int i = 0; i < 16; i++) exp_q.push_back(18'h100C0 + 18'(i));
    exp_q.push_back(18'h00080);
    exp_q.push_back(18'h20042);
    check_seq("f1", 0);

    // Second frame: one register and the control word changed.
    wr(4'd0, 8'h3F);
    brightness = 3'd7; show = 1'b1;
    start_frame(0);
    wait_done(0, "f2", n, b);
    exp_q.delete();
    exp_q.push_back(18'h00044); exp_q.push_back(18'h13FC0);
    exp_q.push_back(18'h0008F); exp_q.push_back(18'h20042);
    check_seq("f2", 0);

    // Single-register updates, some with control changes.
    for (int v = 0; v < 4; v++) begin
      wr(vecs[v].addr, vecs[v].data);
      brightness = vecs[v].bri; show = vecs[v].shw;
      start_frame(0);
      wait_done(0, $sformatf("vec%0d", v), n, b);
      exp_q.delete();
      exp_q.push_back(18'h00044);
      exp_q.push_back(vecs[v].exp_addr);
      if (vecs[v].has_ctrl) exp_q.push_back(vecs[v].exp_ctrl);
      exp_q.push_back(18'h20042);
      check_seq($sformatf("vec%0d", v), 0);
    end

    // Stall on the reg 3 address word while reg 3 is rewritten.
    wr(4'd3, 8'h11);
    start_frame(0);
    n = 0;
    while (!(vld0 && word0 == 18'h111C3) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall reg3 word reached", 32'(vld0 && word0 == 18'h111C3), 32'd1);
    cmd_ready = 1'b0;
    fb_we = 1'b1; fb_addr = 4'd3; fb_data = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      fb_we = 1'b0;
      check($sformatf("stall hold valid %0d", k), 32'(vld0), 32'd1);
      check($sformatf("stall hold word %0d", k), 32'(word0), 32'h111C3);
    end
    cmd_ready = 1'b1;
    wait_done(0, "stall", n, b);
    exp_q.delete();
    exp_q.push_back(18'h00044); exp_q.push_back(18'h111C3); exp_q.push_back(18'h20042);
    check_seq("stall", 0);
    start_frame(0);
    wait_done(0, "resend", n, b);
    exp_q.delete();
    exp_q.push_back(18'h00044); exp_q.push_back(18'h155C3); exp_q.push_back(18'h20042);
    check_seq("resend", 0);

    // Two grids, no SEG8/9, full refresh; odd index write ignored.
    wr(4'd2, 8'h5A);
    wr(4'd1, 8'h77);
    for (int f = 0; f < 2; f++) begin
      start_frame(2);
      wait_done(2, $sformatf("s2f%0d", f), n, b);
      exp_q.delete();
      exp_q.push_back(18'h00044); exp_q.push_back(18'h13FC0);
      exp_q.push_back(18'h15AC2); exp_q.push_back(18'h00083);
      exp_q.push_back(18'h20042);
      check_seq($sformatf("s2f%0d", f), 2);
    end

    // Empty frame timing on the no-key-scan instance (after a flush frame).
    start_frame(1);
    wait_done(1, "nk flush", n, b);
    start_frame(1);
    check("empty busy after start", 32'(busy1), 32'd1);
    wait_done(1, "empty", n, b);
    check("empty done latency", 32'(n), 32'd3);
    check("empty word count", 32'(q1.size()), 32'd0);
    check("empty done pulse width", 32'(done1), 32'd0);
    check("empty busy after done", 32'(busy1), 32'd0);

    // Reset in the middle of the register scan.
    wr(4'd10, 8'h42);
    start_frame(0);
    repeat (3) begin @(posedge clk); #1; end
    check("midscan busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort cmd_valid", 32'(vld0), 32'd0);
    check("abort busy", 32'(busy0), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort no frame_done", 32'(seen), 32'd0);
    start_frame(0);
    wait_done(0, "postrst", n, b);
    exp_q.delete();
    exp_q.push_back(18'h00044);
    for (int i = 0; i < 16; i++) exp_q.push_back(18'h100C0 + 18'(i));
    exp_q.push_back(18'h00083);
    exp_q.push_back(18'h20042);
    check_seq("postrst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
